bf_run_ctrl: RTL and testbench
==============================

# bf_run_ctrl

Run controller for the brainfuck core. It owns the program RAM and data RAM ports and steps through a fixed sequence: load a program from a byte stream, zero the data RAM, then release the core and detect its halt. While the core runs, it has exclusive use of both RAMs through a state-selected mux. It sits between the host byte link and the `proc` instance.

## Interface
- `PROG_ADDR_WIDTH`, 8, program RAM address width
- `DATA_ADDR_WIDTH`, 8, data RAM address width
- `VALUE_WIDTH`, 8, RAM word width; the program byte is `in_data[VALUE_WIDTH-1:0]`

- `clk`  in  1  single clock
- `reset`  in  1  asynchronous, active-high reset
- `load_start`  in  1  single-cycle pulse; honoured only in IDLE or DONE
- `abort`  in  1  level; forces IDLE
- `in_data`  in  8  program byte
- `in_valid`  in  1  byte valid
- `in_ready`  out  1  byte accepted when `in_valid && in_ready`
- `core_prog_addr`  in  PROG_ADDR_WIDTH  core fetch address
- `core_prog_ren`  in  1  core fetch enable
- `core_data_addr`, `core_data_wval`  in  DATA_ADDR_WIDTH / VALUE_WIDTH  core data port
- `core_data_wen`, `core_data_ren`  in  1  core data strobes
- `prog_rval`  in  VALUE_WIDTH  program RAM read data; one-cycle synchronous read
- `core_reset`, `core_en`  out  1  drive `proc` reset and enable
- `pm_addr`, `pm_wval`, `pm_wen`, `pm_ren`  out  program RAM port
- `dm_addr`, `dm_wval`, `dm_wen`, `dm_ren`  out  data RAM port
- `busy`  out  1  state is LOAD, CLEAR or RUN
- `done`  out  1  state is DONE
- `overflow`  out  1  the last load was truncated
- `prog_len`  out  PROG_ADDR_WIDTH+1  bytes written, including the terminator
- `run_cycles`  out  32  count of cycles spent in RUN

## Operation
- States are IDLE, LOAD, CLEAR, RUN and DONE. Reset puts the block in IDLE.
- On reset, every output is 0 except `core_reset=1` and `core_en=1`.
- IDLE
  - `core_reset=1`, `core_en=1`, so the core sits in its reset state.
  - RAM write strobes are 0.
  - `load_start` moves to LOAD. It clears the write pointer, `prog_len`, `overflow` and `run_cycles`.
- LOAD
  - `in_ready=1` until the terminator has been accepted.
  - Each accepted byte is registered into `pm_addr`=ptr, `pm_wval`, `pm_wen=1` on the next cycle, then ptr increments.
  - Byte 0x00 is the terminator. After it is written, go to CLEAR.
  - Overflow: if ptr equals 2^PROG_ADDR_WIDTH-1 and the byte is nonzero, write 0x00 instead. Set `overflow=1` and treat the byte as the terminator.
  - `prog_len` equals ptr after each write.
- CLEAR
  - Writes 0 to data addresses 0..2^DATA_ADDR_WIDTH-1, one per cycle, with `dm_wen=1`.
  - After the last address, go to RUN.
  - `core_reset` and `core_en` stay at 1.
- RUN
  - `core_reset=0`, `core_en=1`.
  - `pm_*` and `dm_*` combinationally mirror the `core_*` inputs; `pm_wen=0`.
  - `run_cycles` increments every RUN cycle and saturates at 0xFFFFFFFF.
- Halt detect
  - A register `fetch_pend` is set to `core_prog_ren`.
  - If `fetch_pend && prog_rval==0`, go to DONE.
- DONE
  - `core_en=0` and `core_reset=0`, which freezes the core and holds its `stdout`.
  - `pm_*` and `dm_*` writes are 0.
  - `load_start` moves to LOAD.
- `abort` high in any state moves to IDLE on the next edge and drops `in_ready` that same edge. It overrides `load_start`; counters hold.
- `load_start` outside IDLE and DONE is ignored.

## Timing
- Load: handshake on edge N puts the RAM write on edge N+1. Sustained rate is 1 byte/cycle.
- LOAD to CLEAR: the edge after the terminator write.
- CLEAR lasts exactly 2^DATA_ADDR_WIDTH cycles.
- Halt latency: fetch of 0x00 with `core_prog_ren` high in cycle N, `prog_rval` valid in cycle N+1, DONE from edge N+1. This matches the core's own EX-stage stop.
- `run_cycles` counts RUN cycles up to and including cycle N+1.
- All status outputs and `in_ready` are registered. The RAM mux is combinational on the registered state.
- Asynchronous `reset` mid-operation returns to IDLE immediately. RAM contents are not restored.

## Test plan
- Load "+." with 0x00 terminator, DATA_ADDR_WIDTH=8 -> writes 0x2B@0, 0x2E@1, 0x00@2; `prog_len`=3; 256 zero writes; RUN; core prints 0x01; DONE; `run_cycles` equals the measured cycle count of the core run.
- PROG_ADDR_WIDTH=2, stream 0x2B×5 with no terminator -> 0x2B@0..2, 0x00@3; `overflow`=1; `in_ready` low after the 4th byte; 5th byte never accepted.
- `in_valid` toggling 1,0,0,1,1,0 during LOAD -> writes occur only on handshake cycles; addresses stay contiguous.
- `abort` in cycle 3 of RUN -> IDLE next edge; `core_reset`=1; `busy`=0; later `load_start` reloads cleanly.
- Asynchronous `reset` mid-CLEAR at address 0x40 -> outputs immediately at reset values; no further `dm_wen`.
- Program "+[-]" -> loop runs; nonzero fetches never trigger DONE; DONE exactly one cycle after the 0x00 fetch enable.

Source files
------------

// File: rtl/bf_run_ctrl.sv
`timescale 1ns/1ps
// Run controller for the brainfuck core: streams a program into program RAM,
// zeroes data RAM, releases the core and freezes it once it fetches a 0x00 opcode.
module bf_run_ctrl #(
  parameter int PROG_ADDR_WIDTH = 8,
  parameter int DATA_ADDR_WIDTH = 8,
  parameter int VALUE_WIDTH     = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       load_start,
  input  logic                       abort,
  input  logic [VALUE_WIDTH-1:0]     in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [PROG_ADDR_WIDTH-1:0] core_prog_addr,
  input  logic                       core_prog_ren,
  input  logic [DATA_ADDR_WIDTH-1:0] core_data_addr,
  input  logic [VALUE_WIDTH-1:0]     core_data_wval,
  input  logic                       core_data_wen,
  input  logic                       core_data_ren,
  input  logic [VALUE_WIDTH-1:0]     prog_rval,
  output logic                       core_reset,
  output logic                       core_en,
  output logic [PROG_ADDR_WIDTH-1:0] pm_addr,
  output logic [VALUE_WIDTH-1:0]     pm_wval,
  output logic                       pm_wen,
  output logic                       pm_ren,
  output logic [DATA_ADDR_WIDTH-1:0] dm_addr,
  output logic [VALUE_WIDTH-1:0]     dm_wval,
  output logic                       dm_wen,
  output logic                       dm_ren,
  output logic                       busy,
  output logic                       done,
  output logic                       overflow,
  output logic [PROG_ADDR_WIDTH:0]   prog_len,
  output logic [31:0]                run_cycles
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CLEAR,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [PROG_ADDR_WIDTH:0]   PTR_LAST   = {1'b0, {PROG_ADDR_WIDTH{1'b1}}};
  localparam logic [DATA_ADDR_WIDTH-1:0] CLEAR_LAST = {DATA_ADDR_WIDTH{1'b1}};

  state_t                     state;
  logic [PROG_ADDR_WIDTH:0]   ptr;
  logic [DATA_ADDR_WIDTH-1:0] clr_addr;
  logic                       ld_wen;
  logic                       ld_term;
  logic [PROG_ADDR_WIDTH-1:0] ld_addr;
  logic [VALUE_WIDTH-1:0]     ld_wval;
  logic                       fetch_pend;

  // Accepted bytes land in the ld_* registers and are written one cycle later;
  // ld_term marks the write that ends the load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      ptr        <= '0;
      clr_addr   <= '0;
      ld_wen     <= 1'b0;
      ld_term    <= 1'b0;
      ld_addr    <= '0;
      ld_wval    <= '0;
      fetch_pend <= 1'b0;
      in_ready   <= 1'b0;
      core_reset <= 1'b1;
      core_en    <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      overflow   <= 1'b0;
      prog_len   <= '0;
      run_cycles <= '0;
    end else if (abort) begin
      state      <= S_IDLE;
      ld_wen     <= 1'b0;
      ld_term    <= 1'b0;
      fetch_pend <= 1'b0;
      in_ready   <= 1'b0;
      core_reset <= 1'b1;
      core_en    <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      ld_wen     <= 1'b0;
      fetch_pend <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (load_start) begin
            state      <= S_LOAD;
            ptr        <= '0;
            ld_term    <= 1'b0;
            prog_len   <= '0;
            overflow   <= 1'b0;
            run_cycles <= '0;
            in_ready   <= 1'b1;
            core_reset <= 1'b1;
            core_en    <= 1'b1;
            busy       <= 1'b1;
            done       <= 1'b0;
          end
        end
        S_LOAD: begin
          if (ld_wen) begin
            prog_len <= ptr;
          end
          if (ld_wen && ld_term) begin
            state    <= S_CLEAR;
            clr_addr <= '0;
          end else if (in_valid && in_ready) begin
            ld_wen  <= 1'b1;
            ld_addr <= ptr[PROG_ADDR_WIDTH-1:0];
            ptr     <= ptr + 1'b1;
            // The last slot always holds a terminator, even if the stream has more.
            if (ptr == PTR_LAST && in_data != '0) begin
              ld_wval  <= '0;
              overflow <= 1'b1;
              ld_term  <= 1'b1;
              in_ready <= 1'b0;
            end else begin
              ld_wval <= in_data;
              if (in_data == '0) begin
                ld_term  <= 1'b1;
                in_ready <= 1'b0;
              end
            end
          end
        end
        S_CLEAR: begin
          clr_addr <= clr_addr + 1'b1;
          if (clr_addr == CLEAR_LAST) begin
            state      <= S_RUN;
            core_reset <= 1'b0;
          end
        end
        S_RUN: begin
          fetch_pend <= core_prog_ren;
          if (run_cycles != 32'hFFFF_FFFF) begin
            run_cycles <= run_cycles + 32'd1;
          end
          // A zero opcode returned for a real fetch is the program end.
          if (fetch_pend && prog_rval == '0) begin
            state      <= S_DONE;
            fetch_pend <= 1'b0;
            core_en    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    pm_addr = ld_addr;
    pm_wval = ld_wval;
    pm_wen  = ld_wen;
    pm_ren  = 1'b0;
    dm_addr = clr_addr;
    dm_wval = '0;
    dm_wen  = (state == S_CLEAR);
    dm_ren  = 1'b0;
    if (state == S_RUN) begin
      pm_addr = core_prog_addr;
      pm_wval = '0;
      pm_wen  = 1'b0;
      pm_ren  = core_prog_ren;
      dm_addr = core_data_addr;
      dm_wval = core_data_wval;
      dm_wen  = core_data_wen;
      dm_ren  = core_data_ren;
    end
  end

endmodule

// File: tb/tb_bf_run_ctrl.sv
`timescale 1ns/1ps
// Directed bench for bf_run_ctrl: RAM models, expected-write scoreboard,
// and emulated core fetch sequences for halt detection.
module tb_bf_run_ctrl;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] val;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_start;
  logic        abort;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  core_prog_addr;
  logic        core_prog_ren;
  logic [7:0]  core_data_addr;
  logic [7:0]  core_data_wval;
  logic        core_data_wen;
  logic        core_data_ren;
  logic [7:0]  prog_rval;
  logic        core_reset;
  logic        core_en;
  logic [7:0]  pm_addr;
  logic [7:0]  pm_wval;
  logic        pm_wen;
  logic        pm_ren;
  logic [7:0]  dm_addr;
  logic [7:0]  dm_wval;
  logic        dm_wen;
  logic        dm_ren;
  logic        busy;
  logic        done;
  logic        overflow;
  logic [8:0]  prog_len;
  logic [31:0] run_cycles;

  logic [7:0] prog_mem [256];
  logic [7:0] data_mem [256];

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  mp = 0;
  int  clr_count = 0;
  int  clr_bad = 0;

  bf_run_ctrl dut (
    .clk(clk), .reset(reset), .load_start(load_start), .abort(abort),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .core_prog_addr(core_prog_addr), .core_prog_ren(core_prog_ren),
    .core_data_addr(core_data_addr), .core_data_wval(core_data_wval),
    .core_data_wen(core_data_wen), .core_data_ren(core_data_ren),
    .prog_rval(prog_rval), .core_reset(core_reset), .core_en(core_en),
    .pm_addr(pm_addr), .pm_wval(pm_wval), .pm_wen(pm_wen), .pm_ren(pm_ren),
    .dm_addr(dm_addr), .dm_wval(dm_wval), .dm_wen(dm_wen), .dm_ren(dm_ren),
    .busy(busy), .done(done), .overflow(overflow), .prog_len(prog_len),
    .run_cycles(run_cycles)
  );

  always #5 clk = ~clk;

  // Synchronous-read program RAM and plain data RAM behind the controller.
  always @(posedge clk) begin
    if (pm_wen) prog_mem[pm_addr] <= pm_wval;
    if (pm_ren) prog_rval <= prog_mem[pm_addr];
    if (dm_wen) data_mem[dm_addr] <= dm_wval;
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Every program write is popped against the queue filled at handshake time.
  always @(negedge clk) begin
    wr_t w;
    if (!reset) begin
      if (pm_wen) begin
        checkOutput("pm_write_pending", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          w = exp_q.pop_front();
          checkOutput("pm_addr", 64'(pm_addr), 64'(w.addr));
          checkOutput("pm_wval", 64'(pm_wval), 64'(w.val));
        end
      end
      if (dm_wen && busy && core_reset) begin
        if (dm_addr !== clr_count[7:0] || dm_wval !== 8'h00) clr_bad++;
        clr_count++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic startLoad();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] b, output logic acc);
    wr_t w;
    in_valid = v;
    in_data  = b;
    @(negedge clk);
    acc = v && in_ready;
    if (acc) begin
      w.addr = mp[7:0];
      w.val  = (mp == 255 && b != 8'h00) ? 8'h00 : b;
      exp_q.push_back(w);
      mp++;
    end
    tick();
  endtask

  task automatic waitClearStart(output int guard);
    guard = 0;
    @(negedge clk);
    while (!dm_wen && guard < 8) begin
      tick();
      @(negedge clk);
      guard++;
    end
    checkOutput("clear_start", 64'(dm_wen), 64'd1);
  endtask

  // Leaves the bench at the start of the first RUN cycle.
  task automatic runClear(input int exp_len, input int exp_guard);
    int guard;
    waitClearStart(guard);
    checkOutput("clear_entry_cycle", 64'(guard), 64'(exp_guard));
    checkOutput("clear_addr0", 64'(dm_addr), 64'd0);
    checkOutput("prog_len", 64'(prog_len), 64'(exp_len));
    for (int i = 0; i < 255; i++) tick();
    @(negedge clk);
    checkOutput("clear_last_addr", 64'(dm_addr), 64'd255);
    checkOutput("clear_core_reset", 64'(core_reset), 64'd1);
    tick();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic acc;
    int   acc_cnt;
    int   guard;
    int   seq [9];
    logic [7:0] tog_data [8];
    logic       tog_valid [8];

    reset = 1'b1; load_start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    core_prog_addr = 8'h00; core_prog_ren = 1'b0; core_data_addr = 8'h00;
    core_data_wval = 8'h00; core_data_wen = 1'b0; core_data_ren = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_core_reset", 64'(core_reset), 64'd1);
    checkOutput("rst_core_en", 64'(core_en), 64'd1);
    checkOutput("rst_in_ready", 64'(in_ready), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_done", 64'(done), 64'd0);
    checkOutput("rst_overflow", 64'(overflow), 64'd0);
    checkOutput("rst_prog_len", 64'(prog_len), 64'd0);
    checkOutput("rst_run_cycles", 64'(run_cycles), 64'd0);
    checkOutput("rst_pm_wen", 64'(pm_wen), 64'd0);
    checkOutput("rst_dm_wen", 64'(dm_wen), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    tick();

    // "+." program, then emulate three fetches ending on the terminator.
    $display("[TB] program +.");
    clr_count = 0; clr_bad = 0; mp = 0;
    startLoad();
    @(negedge clk);
    checkOutput("load_in_ready", 64'(in_ready), 64'd1);
    checkOutput("load_busy", 64'(busy), 64'd1);
    tick();
    applyStimulus(1'b1, 8'h2B, acc);
    applyStimulus(1'b1, 8'h2E, acc);
    applyStimulus(1'b1, 8'h00, acc);
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("term_write_pm_wen", 64'(pm_wen), 64'd1);
    checkOutput("term_in_ready", 64'(in_ready), 64'd0);
    checkOutput("term_dm_wen", 64'(dm_wen), 64'd0);
    runClear(3, 0);
    core_prog_addr = 8'd0; core_prog_ren = 1'b1;
    @(negedge clk);
    checkOutput("clear_count", 64'(clr_count), 64'd256);
    checkOutput("clear_bad", 64'(clr_bad), 64'd0);
    checkOutput("run_core_reset", 64'(core_reset), 64'd0);
    checkOutput("run_core_en", 64'(core_en), 64'd1);
    checkOutput("run_pm_ren", 64'(pm_ren), 64'd1);
    checkOutput("run_pm_wen", 64'(pm_wen), 64'd0);
    tick();
    core_prog_addr = 8'd1;
    core_data_addr = 8'h00; core_data_wval = 8'h01; core_data_wen = 1'b1;
    @(negedge clk);
    checkOutput("run_pm_addr", 64'(pm_addr), 64'd1);
    checkOutput("run_dm_wen", 64'(dm_wen), 64'd1);
    checkOutput("run_dm_wval", 64'(dm_wval), 64'd1);
    tick();
    core_prog_addr = 8'd2; core_data_wen = 1'b0; core_data_ren = 1'b1;
    @(negedge clk);
    checkOutput("run_dm_ren", 64'(dm_ren), 64'd1);
    checkOutput("run_done_early", 64'(done), 64'd0);
    tick();
    core_prog_ren = 1'b0; core_data_ren = 1'b0;
    @(negedge clk);
    checkOutput("halt_not_yet", 64'(done), 64'd0);
    tick();
    @(negedge clk);
    checkOutput("halt_done", 64'(done), 64'd1);
    checkOutput("halt_core_en", 64'(core_en), 64'd0);
    checkOutput("halt_core_reset", 64'(core_reset), 64'd0);
    checkOutput("halt_busy", 64'(busy), 64'd0);
    checkOutput("halt_run_cycles", 64'(run_cycles), 64'd4);
    checkOutput("halt_data_cell", 64'(data_mem[0]), 64'd1);
    tick();

    // Unterminated 0x2B stream: last slot forced to 0x00, excess byte refused.
    $display("[TB] overflow stream");
    clr_count = 0; clr_bad = 0; mp = 0; acc_cnt = 0;
    startLoad();
    @(negedge clk);
    checkOutput("reload_run_cycles", 64'(run_cycles), 64'd0);
    checkOutput("reload_done", 64'(done), 64'd0);
    checkOutput("reload_core_reset", 64'(core_reset), 64'd1);
    tick();
    for (int i = 0; i < 257; i++) begin
      applyStimulus(1'b1, 8'h2B, acc);
      if (acc) acc_cnt++;
    end
    in_valid = 1'b0;
    checkOutput("ovf_accepted", 64'(acc_cnt), 64'd256);
    checkOutput("ovf_in_ready", 64'(in_ready), 64'd0);
    checkOutput("ovf_flag", 64'(overflow), 64'd1);
    runClear(256, 0);
    tick();
    tick();
    abort = 1'b1;
    @(negedge clk);
    checkOutput("abort_same_cycle_busy", 64'(busy), 64'd1);
    tick();
    abort = 1'b0;
    @(negedge clk);
    checkOutput("abort_core_reset", 64'(core_reset), 64'd1);
    checkOutput("abort_busy", 64'(busy), 64'd0);
    checkOutput("abort_run_cycles_hold", 64'(run_cycles), 64'd2);
    checkOutput("abort_overflow_hold", 64'(overflow), 64'd1);
    tick();

    // "+[-]" loaded with gaps in in_valid; loop fetches must not halt.
    $display("[TB] program +[-] with valid gaps");
    clr_count = 0; clr_bad = 0; mp = 0;
    tog_valid = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    tog_data  = '{8'h2B, 8'h00, 8'h00, 8'h5B, 8'h2D, 8'h00, 8'h5D, 8'h00};
    startLoad();
    @(negedge clk);
    checkOutput("reload_overflow_clear", 64'(overflow), 64'd0);
    checkOutput("reload_prog_len_clear", 64'(prog_len), 64'd0);
    tick();
    for (int i = 0; i < 8; i++) applyStimulus(tog_valid[i], tog_data[i], acc);
    in_valid = 1'b0;
    checkOutput("gap_accepted", 64'(mp), 64'd5);
    runClear(5, 1);
    seq = '{0, 1, 2, 3, 1, 2, 3, 4, -1};
    for (int i = 0; i < 9; i++) begin
      core_prog_ren  = (seq[i] >= 0);
      core_prog_addr = (seq[i] >= 0) ? 8'(seq[i]) : 8'h00;
      load_start     = (i == 3);
      @(negedge clk);
      checkOutput("loop_no_halt", 64'(done), 64'd0);
      if (i == 4) begin
        checkOutput("ignored_start_busy", 64'(busy), 64'd1);
        checkOutput("ignored_start_core_reset", 64'(core_reset), 64'd0);
        checkOutput("ignored_start_in_ready", 64'(in_ready), 64'd0);
      end
      tick();
    end
    load_start = 1'b0;
    @(negedge clk);
    checkOutput("loop_halt_done", 64'(done), 64'd1);
    checkOutput("loop_run_cycles", 64'(run_cycles), 64'd9);
    tick();

    // Asynchronous reset in the middle of the clear sweep.
    $display("[TB] reset mid-clear");
    clr_count = 0; clr_bad = 0; mp = 0;
    startLoad();
    applyStimulus(1'b1, 8'h2B, acc);
    applyStimulus(1'b1, 8'h00, acc);
    in_valid = 1'b0;
    waitClearStart(guard);
    for (int i = 0; i < 64; i++) tick();
    @(negedge clk);
    checkOutput("mid_clear_addr", 64'(dm_addr), 64'h40);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("async_dm_wen", 64'(dm_wen), 64'd0);
    checkOutput("async_core_reset", 64'(core_reset), 64'd1);
    checkOutput("async_busy", 64'(busy), 64'd0);
    checkOutput("async_prog_len", 64'(prog_len), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (4) tick();
    @(negedge clk);
    checkOutput("post_reset_clear_count", 64'(clr_count), 64'd65);
    checkOutput("post_reset_clear_bad", 64'(clr_bad), 64'd0);
    checkOutput("post_reset_dm_wen", 64'(dm_wen), 64'd0);
    checkOutput("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
